// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED PIO arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK,
    HOLD
  } arb_state_t;

  // Who owns the transaction in flight; SRC_TICK only occurs with the blink feature.
  typedef enum logic [1:0] {
    SRC_REQ0,
    SRC_REQ1,
    SRC_TICK
  } arb_src_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;
  localparam int         PIO_DATA_W    = 32;

endpackage

// File: rtl/led_rr_arb2.sv
// Two-input round-robin arbiter: on a tie, the requester that lost the previous grant wins.
module led_rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt0,
  output logic gnt1
);

  logic prefer1_q;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      gnt0 = !prefer1_q;
      gnt1 = prefer1_q;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // After a grant, the other requester becomes preferred for the next tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prefer1_q <= 1'b0;
    end else if (advance && (gnt0 || gnt1)) begin
      prefer1_q <= gnt0;
    end
  end

endmodule

// File: rtl/led_pio_arbiter.sv
// Arbitrates two LED-value requesters onto a single PIO data register with a minimum write spacing.
// Optional periodic blink writes are enabled by defining LED_ARB_BLINK_EN.
module led_pio_arbiter
  import led_arb_pkg::*;
#(
  parameter int WIDTH       = 14,
  parameter int HOLD_CYCLES = 1024,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef LED_ARB_BLINK_EN
  input  logic [WIDTH-1:0]      blink_mask,
`endif
  input  logic                  req0_valid,
  input  logic [WIDTH-1:0]      req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [WIDTH-1:0]      req1_data,
  output logic                  req1_ready,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [PIO_DATA_W-1:0] pio_writedata,
  output logic [WIDTH-1:0]      leds_shadow
);

  // WRITE + ACK + HOLD + IDLE make up the spacing, so HOLD lasts HOLD_CYCLES-3 cycles.
  localparam bit              USE_HOLD  = (HOLD_CYCLES > 3);
  localparam int              HCW       = (HOLD_CYCLES > 4) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0]  HOLD_LOAD = USE_HOLD ? HCW'(HOLD_CYCLES - 3) : '0;

  arb_state_t       state_q, state_d;
  arb_src_t         gnt_src_q;
  logic [WIDTH-1:0] gnt_data_q;
  logic [HCW-1:0]   hold_cnt_q;
  logic [WIDTH-1:0] shadow_q;
  logic             gnt0, gnt1;
  logic             take_req;

  led_rr_arb2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0_valid),
    .req1    (req1_valid),
    .advance (take_req),
    .gnt0    (gnt0),
    .gnt1    (gnt1)
  );

`ifdef LED_ARB_BLINK_EN
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BCW-1:0] blink_cnt_q;
  logic           tick_pending_q;
  logic           blink_wrap;
  logic           take_tick;

  assign blink_wrap = (blink_cnt_q == BCW'(BLINK_DIV - 1));

  // A wrap coinciding with a tick being taken re-arms the flag, so no tick is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q    <= '0;
      tick_pending_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_wrap ? '0 : blink_cnt_q + 1'b1;
      if (blink_wrap) begin
        tick_pending_q <= 1'b1;
      end else if (take_tick) begin
        tick_pending_q <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    take_req = 1'b0;
`ifdef LED_ARB_BLINK_EN
    take_tick = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Requesters outrank a pending blink tick.
        if (gnt0 || gnt1) begin
          take_req = 1'b1;
          state_d  = WRITE;
        end
`ifdef LED_ARB_BLINK_EN
        else if (tick_pending_q) begin
          take_tick = 1'b1;
          state_d   = WRITE;
        end
`endif
      end
      WRITE:   state_d = ACK;
      ACK:     state_d = USE_HOLD ? HOLD : IDLE;
      HOLD:    if (hold_cnt_q <= HCW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_src_q  <= SRC_REQ0;
      gnt_data_q <= '0;
      hold_cnt_q <= '0;
      shadow_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state_q <= state_d;

      // Data is captured at grant time; later changes on the requester side are ignored.
      if (take_req) begin
        gnt_src_q  <= gnt1 ? SRC_REQ1 : SRC_REQ0;
        gnt_data_q <= gnt1 ? req1_data : req0_data;
      end
`ifdef LED_ARB_BLINK_EN
      else if (take_tick) begin
        gnt_src_q  <= SRC_TICK;
        gnt_data_q <= shadow_q ^ blink_mask;
      end
`endif

      if (state_q == WRITE) begin
        shadow_q <= gnt_data_q;
      end

      if (state_q == ACK) begin
        hold_cnt_q <= HOLD_LOAD;
      end else if (state_q == HOLD && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end
    end
  end

  assign pio_address    = PIO_DATA_ADDR;
  assign pio_chipselect = (state_q == WRITE);
  assign pio_write_n    = (state_q != WRITE);
  assign pio_writedata  = (state_q == WRITE) ? PIO_DATA_W'(gnt_data_q) : '0;
  assign leds_shadow    = shadow_q;

  // A tick-owned transaction never pulses either ready.
  assign req0_ready = (state_q == ACK) && (gnt_src_q == SRC_REQ0);
  assign req1_ready = (state_q == ACK) && (gnt_src_q == SRC_REQ1);

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Directed self-checking bench for led_pio_arbiter (WIDTH=14, HOLD_CYCLES=16).
module tb_led_pio_arbiter;

  localparam int WIDTH = 14;
  localparam int HOLD  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic [1:0]       pio_address;
  logic             pio_chipselect, pio_write_n;
  logic [31:0]      pio_writedata;
  logic [WIDTH-1:0] leds_shadow;
`ifdef LED_ARB_BLINK_EN
  logic [WIDTH-1:0] blink_mask = '0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_pio_arbiter #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .clk            (clk),
    .reset          (reset),
`ifdef LED_ARB_BLINK_EN
    .blink_mask     (blink_mask),
`endif
    .req0_valid     (req0_valid),
    .req0_data      (req0_data),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_data      (req1_data),
    .req1_ready     (req1_ready),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .leds_shadow    (leds_shadow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances on falling edges until a write strobe is visible or the budget runs out.
  task automatic wait_write(input int max_cyc, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (pio_chipselect === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int cyc;

    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    repeat (3) @(negedge clk);

    check("rst_cs",     32'(pio_chipselect), 32'd1 - 32'd1);
    check("rst_wn",     32'(pio_write_n),    32'd1);
    check("rst_wdata",  pio_writedata,       32'h0);
    check("rst_shadow", 32'(leds_shadow),    32'h0);
    check("rst_rdy0",   32'(req0_ready),     32'h0);
    check("rst_rdy1",   32'(req1_ready),     32'h0);
    check("rst_addr",   32'(pio_address),    32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Single request from requester 0.
    req0_valid = 1'b1;
    req0_data  = 14'h2AA;
    wait_write(4, seen, cyc);
    check("single_seen",  32'(seen),          32'd1);
    check("single_lat",   32'(cyc),           32'd1);
    check("single_wdata", pio_writedata,      32'h0000_02AA);
    check("single_wn",    32'(pio_write_n),   32'h0);
    check("single_addr",  32'(pio_address),   32'h0);
    check("single_rdy_w", 32'(req0_ready),    32'h0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("single_rdy0",  32'(req0_ready),     32'h1);
    check("single_rdy1",  32'(req1_ready),     32'h0);
    check("single_cs_a",  32'(pio_chipselect), 32'h0);
    check("single_shad",  32'(leds_shadow),    32'h2AA);
    @(negedge clk);
    check("single_rdy_end", 32'(req0_ready),   32'h0);

    // A request raised and dropped during HOLD is simply lost.
    @(negedge clk);
    req1_valid = 1'b1;
    req1_data  = 14'h111;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_write(30, seen, cyc);
    check("drop_no_write", 32'(seen),        32'h0);
    check("drop_shadow",   32'(leds_shadow), 32'h2AA);

    // Data changed after grant must not affect the write.
    req0_valid = 1'b1;
    req0_data  = 14'h123;
    wait_write(4, seen, cyc);
    check("cap_seen",  32'(seen),     32'd1);
    check("cap_wdata", pio_writedata, 32'h123);
    req0_data  = 14'h3FF;
    req0_valid = 1'b0;
    @(negedge clk);
    check("cap_rdy0",   32'(req0_ready),  32'h1);
    check("cap_shadow", 32'(leds_shadow), 32'h123);
    repeat (20) @(negedge clk);

    // Tie after reset: requester 0 first, then alternate.
    pulse_reset();
    req0_valid = 1'b1;
    req0_data  = 14'h0001;
    req1_valid = 1'b1;
    req1_data  = 14'h3FFF;
    wait_write(4, seen, cyc);
    check("tie1_seen",  32'(seen),     32'd1);
    check("tie1_wdata", pio_writedata, 32'h0001);
    @(negedge clk);
    check("tie1_rdy0", 32'(req0_ready), 32'h1);
    check("tie1_rdy1", 32'(req1_ready), 32'h0);
    wait_write(40, seen, cyc);
    check("tie2_gap",   32'(cyc),      32'd15);
    check("tie2_wdata", pio_writedata, 32'h3FFF);
    @(negedge clk);
    check("tie2_rdy0", 32'(req0_ready), 32'h0);
    check("tie2_rdy1", 32'(req1_ready), 32'h1);
    wait_write(40, seen, cyc);
    check("tie3_gap",   32'(cyc),      32'd15);
    check("tie3_wdata", pio_writedata, 32'h0001);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (20) @(negedge clk);

    // Continuous requester 1: strobes exactly HOLD cycles apart.
    pulse_reset();
    req1_valid = 1'b1;
    req1_data  = 14'h155;
    wait_write(4, seen, cyc);
    check("sp0_seen", 32'(seen), 32'd1);
    wait_write(40, seen, cyc);
    check("sp1_gap",   32'(cyc),      32'(HOLD));
    check("sp1_wdata", pio_writedata, 32'h155);
    wait_write(40, seen, cyc);
    check("sp2_gap", 32'(cyc), 32'(HOLD));
    req1_valid = 1'b0;
    repeat (20) @(negedge clk);

    // Reset asserted during WRITE abandons the transaction.
    pulse_reset();
    req0_valid = 1'b1;
    req0_data  = 14'h0AB;
    wait_write(4, seen, cyc);
    check("mid_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_cs",     32'(pio_chipselect), 32'h0);
    check("mid_wn",     32'(pio_write_n),    32'h1);
    check("mid_wdata",  pio_writedata,       32'h0);
    check("mid_shadow", 32'(leds_shadow),    32'h0);
    check("mid_rdy0",   32'(req0_ready),     32'h0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_rdy0_b", 32'(req0_ready), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rdy0_c", 32'(req0_ready), 32'h0);
    req1_valid = 1'b1;
    req1_data  = 14'h2C3;
    wait_write(4, seen, cyc);
    check("post_lat",   32'(cyc),      32'd1);
    check("post_wdata", pio_writedata, 32'h2C3);
    req1_valid = 1'b0;
    @(negedge clk);
    check("post_rdy1",   32'(req1_ready),  32'h1);
    check("post_rdy0",   32'(req0_ready),  32'h0);
    check("post_shadow", 32'(leds_shadow), 32'h2C3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
